oam_dma_controller: RTL and testbench

Sprite DMA engine for the CPU bus: detects CPU writes to $4014, halts the CPU, and copies one 256-byte page from the CPU address space into PPU OAM. Each byte is read from `{page, index}` and written to $2004. The block sits beside the CPU as a second bus master, directly upstream of the RAM controller. Its read strobes address work RAM, and it consumes the RAM controller's read data one clock later.

---
 rtl/nes_bus_pkg.sv | 18 +
 rtl/oam_dma_controller.sv | 84 ++++++++
 tb/tb_oam_dma_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: register addresses, RAM window and the OAM DMA state encoding.
package nes_bus_pkg;

    localparam logic [15:0] OAM_DMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    localparam logic [15:0] RAM_START = 16'h0000;
    localparam logic [15:0] RAM_SIZE  = 16'h2000;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite DMA: on a CPU write to the trigger address, halts the CPU and copies one
// 256-byte page into OAM, alternating reads of {page, index} with writes to the OAM data port.
module oam_dma_controller
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_TRIGGER_ADDR = OAM_DMA_ADDR,
    parameter logic [15:0] DMA_TARGET_ADDR  = OAM_DATA_ADDR
) (
    input  logic        dma_clk_in,
    input  logic        dma_reset_in,
    input  logic        dma_tick_in,
    input  logic [15:0] cpu_address_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_in,
    output logic        dma_halt_out,
    output logic [15:0] dma_address_out,
    output logic        dma_read_out,
    output logic        dma_write_out,
    input  logic [7:0]  dma_data_in,
    output logic [7:0]  dma_data_out,
    output logic [15:0] debug_out
);

    dma_state_t state;
    logic       parity;
    logic [7:0] index;
    logic [7:0] page;
    logic [7:0] latch;
    logic       read_pending;

    always_ff @(posedge dma_clk_in) begin
        if (dma_reset_in) begin
            state        <= DMA_IDLE;
            parity       <= 1'b0;
            index        <= 8'h00;
            page         <= 8'h00;
            latch        <= 8'h00;
            read_pending <= 1'b0;
        end else begin
            // RAM data arrives one clock after the read strobe
            read_pending <= dma_read_out;
            if (read_pending)
                latch <= dma_data_in;

            if (dma_tick_in) begin
                parity <= ~parity;
                case (state)
                    DMA_IDLE: begin
                        if (cpu_write_in && cpu_address_in == DMA_TRIGGER_ADDR) begin
                            state <= DMA_HALT;
                            page  <= cpu_data_in;
                            index <= 8'h00;
                        end
                    end
                    // Reads must land on parity 0; insert one ALIGN tick when needed
                    DMA_HALT:  state <= parity ? DMA_READ : DMA_ALIGN;
                    DMA_ALIGN: state <= DMA_READ;
                    DMA_READ:  state <= DMA_WRITE;
                    DMA_WRITE: begin
                        index <= index + 8'd1;
                        state <= (index == 8'hFF) ? DMA_IDLE : DMA_READ;
                    end
                    default:   state <= DMA_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        dma_address_out = 16'h0000;
        case (state)
            DMA_READ:  dma_address_out = {page, index};
            DMA_WRITE: dma_address_out = DMA_TARGET_ADDR;
            default:   dma_address_out = 16'h0000;
        endcase
    end

    assign dma_halt_out  = (state != DMA_IDLE);
    assign dma_read_out  = dma_tick_in && (state == DMA_READ);
    assign dma_write_out = dma_tick_in && (state == DMA_WRITE);
    assign dma_data_out  = latch;
    assign debug_out     = {state[1:0], 2'b00, parity, 3'b000, index};

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: RAM model, bus monitor and transfer-level reference checks.
module tb_oam_dma_controller;
    import nes_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_wr;
    logic        halt;
    logic [15:0] dma_addr;
    logic        rd;
    logic        wr;
    logic [7:0]  ram_q = 8'h00;
    logic [7:0]  dout;
    logic [15:0] dbg;

    always #5 clk = ~clk;

    oam_dma_controller dut (
        .dma_clk_in      (clk),
        .dma_reset_in    (rst),
        .dma_tick_in     (tick),
        .cpu_address_in  (cpu_addr),
        .cpu_data_in     (cpu_data),
        .cpu_write_in    (cpu_wr),
        .dma_halt_out    (halt),
        .dma_address_out (dma_addr),
        .dma_read_out    (rd),
        .dma_write_out   (wr),
        .dma_data_in     (ram_q),
        .dma_data_out    (dout),
        .debug_out       (dbg)
    );

    // Byte-wide memory with one clock of read latency
    logic [7:0] mem [0:65535];
    always @(posedge clk) if (rd) ram_q <= mem[dma_addr];

    int n_assert = 0;
    int n_fail   = 0;

    // Bus monitor: everything observed on clocks that carry a tick
    int          tick_cnt = 0;
    int          halt_ticks, rd_odd, viol;
    logic [15:0] rd_addr_q [$];
    logic [15:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    bit          ev_q [$];
    logic [15:0] prev_addr = 16'h0000;
    bit          prev_tick = 1'b0;
    bit          prev_rst  = 1'b1;

    always @(negedge clk) begin
        if (rd && !tick) viol++;
        if (wr && !tick) viol++;
        if (rd && wr) viol++;
        if (!prev_tick && !prev_rst && dma_addr !== prev_addr) viol++;
        if (rst) tick_cnt = 0;
        else if (tick) begin
            if (halt) halt_ticks++;
            if (rd) begin
                rd_addr_q.push_back(dma_addr);
                ev_q.push_back(1'b0);
                if (tick_cnt % 2 != 0) rd_odd++;
            end
            if (wr) begin
                wr_addr_q.push_back(dma_addr);
                wr_data_q.push_back(dout);
                ev_q.push_back(1'b1);
            end
            tick_cnt++;
        end
        prev_addr = dma_addr;
        prev_tick = tick;
        prev_rst  = rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; issues one tick and idles so the next tick is gap clocks later
    task automatic do_tick(input bit w, input logic [15:0] a, input logic [7:0] d, input int gap);
        int g;
        g = (gap == 0) ? int'($urandom_range(4, 2)) : gap;
        tick = 1'b1; cpu_wr = w; cpu_addr = a; cpu_data = d;
        @(posedge clk); #1;
        tick = 1'b0; cpu_wr = 1'b0;
        repeat (g - 1) begin @(posedge clk); #1; end
    endtask

    task automatic run_xfer(input logic [7:0] page, input int gap, input bit inject);
        int  k, bad_ra, bad_wa, bad_wd, bad_ord;
        bit  tp;
        rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); ev_q.delete();
        halt_ticks = 0; viol = 0; rd_odd = 0;
        tp = (tick_cnt % 2) != 0;
        do_tick(1'b1, OAM_DMA_ADDR, page, gap);
        check("dbg_after_trigger", {16'h0, dbg}, {16'h0, 2'b01, 2'b00, ~tp, 3'b000, 8'h00});
        k = 0;
        while (halt && k < 600) begin
            do_tick(inject && k == 50, OAM_DMA_ADDR, page ^ 8'hFF, gap);
            k++;
        end
        check("xfer_finished", 32'(k < 600), 32'd1);
        check("halt_ticks", 32'(halt_ticks), tp ? 32'd514 : 32'd513);
        check("read_count", 32'(rd_addr_q.size()), 32'd256);
        check("write_count", 32'(wr_addr_q.size()), 32'd256);
        bad_ra = 0; bad_wa = 0; bad_wd = 0; bad_ord = 0;
        if (rd_addr_q.size() == 256 && wr_addr_q.size() == 256 && ev_q.size() == 512) begin
            for (int i = 0; i < 256; i++) begin
                if (rd_addr_q[i] !== {page, i[7:0]}) bad_ra++;
                if (wr_addr_q[i] !== OAM_DATA_ADDR) bad_wa++;
                if (wr_data_q[i] !== mem[{page, i[7:0]}]) bad_wd++;
                if (ev_q[2*i] !== 1'b0 || ev_q[2*i+1] !== 1'b1) bad_ord++;
            end
        end else begin
            bad_ra = -1; bad_wa = -1; bad_wd = -1; bad_ord = -1;
        end
        check("read_addr_errs", 32'(bad_ra), 32'd0);
        check("write_addr_errs", 32'(bad_wa), 32'd0);
        check("write_data_errs", 32'(bad_wd), 32'd0);
        check("rw_order_errs", 32'(bad_ord), 32'd0);
        check("reads_on_odd_parity", 32'(rd_odd), 32'd0);
        check("strobe_addr_violations", 32'(viol), 32'd0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_data = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'h5A;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_halt", {31'h0, halt}, 32'd0);
        check("rst_addr", {16'h0, dma_addr}, 32'd0);
        check("rst_read", {31'h0, rd}, 32'd0);
        check("rst_write", {31'h0, wr}, 32'd0);
        check("rst_data", {24'h0, dout}, 32'd0);
        check("rst_debug", {16'h0, dbg}, 32'd0);

        // Near-miss addresses and a read of the trigger address do nothing
        do_tick(1'b1, 16'h4013, 8'h02, 2);
        check("no_halt_4013", {31'h0, halt}, 32'd0);
        do_tick(1'b1, 16'h4015, 8'h02, 2);
        check("no_halt_4015", {31'h0, halt}, 32'd0);
        do_tick(1'b0, OAM_DMA_ADDR, 8'h02, 2);
        check("no_halt_read_4014", {31'h0, halt}, 32'd0);
        check("idle_parity", {16'h0, dbg}, {16'h0, 2'b00, 2'b00, 1'(tick_cnt % 2), 3'b000, 8'h00});

        // Parity-0 trigger, page 2
        if (tick_cnt % 2 != 0) do_tick(1'b0, 16'h0000, 8'h00, 2);
        run_xfer(8'h02, 0, 1'b0);

        // Parity-1 trigger, page 3 with known pattern
        if (tick_cnt % 2 == 0) do_tick(1'b0, 16'h0000, 8'h00, 2);
        run_xfer(8'h03, 0, 1'b0);

        // Trigger during a transfer is ignored
        run_xfer(8'h05, 0, 1'b1);

        // Fixed 3-clock tick spacing
        run_xfer(8'h10, 3, 1'b0);

        // Reset on the 100th tick of a transfer
        do_tick(1'b1, OAM_DMA_ADDR, 8'h07, 0);
        for (int i = 1; i < 100; i++) do_tick(1'b0, 16'h0000, 8'h00, 0);
        check("pre_abort_halt", {31'h0, halt}, 32'd1);
        rst = 1'b1; tick = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; tick = 1'b0;
        check("abort_halt", {31'h0, halt}, 32'd0);
        check("abort_read", {31'h0, rd}, 32'd0);
        check("abort_write", {31'h0, wr}, 32'd0);
        check("abort_addr", {16'h0, dma_addr}, 32'd0);
        check("abort_data", {24'h0, dout}, 32'd0);
        do_tick(1'b0, 16'h0000, 8'h00, 2);
        check("abort_stays_idle", {31'h0, halt}, 32'd0);
        run_xfer(8'h08, 0, 1'b0);
        run_xfer(8'hFF, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
